// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared VPU constants for SRAM width and operand queue sizing
package vpu_pkg;

    localparam int SRAM_DATA_WIDTH     = 32;
    localparam int OPERAND_Q_DEPTH     = 4;
    localparam int OPERAND_Q_CNT_WIDTH = $clog2(OPERAND_Q_DEPTH) + 1;

endpackage

// File: rtl/vpu_operand_queue.sv
// rtl/vpu_operand_queue.sv - per-operand first-word-fall-through FIFO with sticky overflow
module vpu_operand_queue
    import vpu_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int DEPTH      = OPERAND_Q_DEPTH,
    parameter int AFULL_TH   = DEPTH - 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wren_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    input  logic                      flush_i,
    input  logic                      clr_err_i,
    output logic                      full_o,
    output logic                      almost_full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  push, pop, drop;

    // Status flags come only from registered count so wren/rready never reach them combinationally
    assign full_o        = (count_q == CW'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign almost_full_o = (count_q >= CW'(AFULL_TH));
    assign count_o       = count_q;
    assign rvalid_o      = ~empty_o;
    assign rdata_o       = mem[rptr_q];
    assign overflow_o    = ovf_q;

    // Handshake decode and next-state for pointers, count and sticky overflow
    always_comb begin
        pop     = rvalid_o & rready_i & ~flush_i;
        push    = wren_i & (~full_o | pop) & ~flush_i;
        drop    = wren_i & full_o & ~pop & ~flush_i;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
        // A new drop in the same cycle as a clear leaves the flag set
        if (drop)           ovf_d = 1'b1;
        else if (clr_err_i) ovf_d = 1'b0;
    end

    // Pointer, count and overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage array; cleared on reset so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: tb/tb_vpu_operand_queue.sv
// tb/tb_vpu_operand_queue.sv - self-checking bench for vpu_operand_queue against a queue model
module tb_vpu_operand_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wren_i = 1'b0;
    logic [DW-1:0] wdata_i = '0;
    logic          rvalid_o;
    logic          rready_i = 1'b0;
    logic [DW-1:0] rdata_o;
    logic          flush_i = 1'b0;
    logic          clr_err_i = 1'b0;
    logic          full_o, almost_full_o, empty_o, overflow_o;
    logic [2:0]    count_o;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [DW-1:0] q[$];
    bit            ovf = 1'b0;

    vpu_operand_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(DEPTH-1)) dut (
        .clk(clk), .rst_n(rst_n), .wren_i(wren_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o),
        .flush_i(flush_i), .clr_err_i(clr_err_i), .full_o(full_o),
        .almost_full_o(almost_full_o), .empty_o(empty_o), .count_o(count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 64'(count_o), 64'(q.size()));
        chk({tag, ".empty"}, 64'(empty_o), 64'(q.size() == 0));
        chk({tag, ".full"}, 64'(full_o), 64'(q.size() == DEPTH));
        chk({tag, ".afull"}, 64'(almost_full_o), 64'(q.size() >= DEPTH - 1));
        chk({tag, ".rvalid"}, 64'(rvalid_o), 64'(q.size() != 0));
        chk({tag, ".ovf"}, 64'(overflow_o), 64'(ovf));
        if (q.size() != 0) chk({tag, ".rdata"}, 64'(rdata_o), 64'(q[0]));
    endtask

    // Apply one cycle of inputs, advance the model by the queue rules, then compare
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic f, input logic c);
        bit was_full, do_pop, do_push;
        wren_i = w; wdata_i = d; rready_i = r; flush_i = f; clr_err_i = c;
        was_full = (q.size() == DEPTH);
        do_pop   = (q.size() != 0) && r && !f;
        do_push  = w && (!was_full || do_pop) && !f;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        if (w && was_full && !do_pop && !f) ovf = 1'b1;
        else if (c) ovf = 1'b0;
        #1;
        wren_i = 1'b0; rready_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.rdata", 64'(rdata_o), 64'h0);
        chk_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle then single write; visible the next cycle
        for (int i = 0; i < 4; i++) step("idle", 0, '0, 0, 0, 0);
        step("wr_a5", 1, 32'hA5, 0, 0, 0);
        chk("a5.head", 64'(rdata_o), 64'hA5);
        step("rd_a5", 0, '0, 1, 0, 0);

        // Fill, overflow on the fifth write, drain in order with sticky flag
        for (int i = 1; i <= 4; i++) step("fill", 1, DW'(i), 0, 0, 0);
        chk("fill.full", 64'(full_o), 64'h1);
        step("wr_5_drop", 1, 32'h5, 0, 0, 0);
        chk("drop.ovf", 64'(overflow_o), 64'h1);
        for (int i = 1; i <= 4; i++) begin
            chk("drain.order", 64'(rdata_o), 64'(i));
            step("drain", 0, '0, 1, 0, 0);
        end
        chk("drain.empty", 64'(empty_o), 64'h1);
        step("rd_empty", 0, '0, 1, 0, 0);
        step("clr", 0, '0, 0, 0, 1);

        // Push and pop together while full
        for (int i = 1; i <= 4; i++) step("fill2", 1, DW'(i), 0, 0, 0);
        step("full_pp", 1, 32'h9, 1, 0, 0);
        chk("full_pp.count", 64'(count_o), 64'h4);
        chk("full_pp.ovf", 64'(overflow_o), 64'h0);
        for (int i = 0; i < 4; i++) step("drain2", 0, '0, 1, 0, 0);

        // Streaming with count held at one across pointer wraps
        step("stream0", 1, 32'h100, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step("stream", 1, DW'(32'h100 + i), 1, 0, 0);
            chk("stream.head", 64'(rdata_o), 64'(32'h100 + i));
        end
        step("stream_end", 0, '0, 1, 0, 0);

        // Flush with pending write is ignored
        for (int i = 0; i < 3; i++) step("pre_flush", 1, DW'(32'h20 + i), 0, 0, 0);
        step("flush", 1, 32'hEE, 1, 1, 0);
        chk("flush.empty", 64'(empty_o), 64'h1);
        step("wr_7", 1, 32'h7, 0, 0, 0);
        chk("wr7.head", 64'(rdata_o), 64'h7);
        step("rd_7", 0, '0, 1, 0, 0);

        // Clear coincident with a new drop keeps the flag set
        for (int i = 0; i < 4; i++) step("fill3", 1, DW'(32'h30 + i), 0, 0, 0);
        step("drop1", 1, 32'h99, 0, 0, 0);
        step("clr_and_drop", 1, 32'h98, 0, 0, 1);
        chk("clr_drop.ovf", 64'(overflow_o), 64'h1);
        step("rd_keep_ovf", 0, '0, 1, 0, 0);
        step("clr2", 0, '0, 0, 0, 1);
        chk("clr2.ovf", 64'(overflow_o), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) == 0));

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        ovf = 1'b0;
        chk("arst.rdata", 64'(rdata_o), 64'h0);
        chk_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 200; i++)
            step("rand2", 1'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) == 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
